// File: rtl/rvi_slt_issue_ctrl.sv
// Issue controller for the RVI set-less-than unit (SLT/SLTU/SLTI/SLTIU).
// Latches a decoded op, fires the SLT unit for one cycle, then holds the result for integer writeback.
module rvi_slt_issue_ctrl #(
  parameter int RV64      = 0,
  parameter int CPU_WIDTH = 32 * (RV64 + 1),
  parameter int RD_W      = 5,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 req_vld,
  output logic                 req_rdy,
  input  logic [CPU_WIDTH-1:0] req_s1,
  input  logic [CPU_WIDTH-1:0] req_s2,
  input  logic [11:0]          req_imm,
  input  logic                 req_immFlg,
  input  logic                 req_unsigned,
  input  logic [RD_W-1:0]      req_rd,
  output logic                 slt_en,
  output logic [CPU_WIDTH-1:0] slt_s1,
  output logic [CPU_WIDTH-1:0] slt_s2,
  output logic                 slt_unsigned,
  input  logic [CPU_WIDTH-1:0] slt_rslt,
  output logic                 wb_vld,
  input  logic                 wb_rdy,
  output logic [RD_W-1:0]      wb_rd,
  output logic [CPU_WIDTH-1:0] wb_data,
  output logic [CNT_W-1:0]     retire_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t               r_state;
  state_t               w_nxt_state;
  logic [CPU_WIDTH-1:0] r_s1;
  logic [CPU_WIDTH-1:0] r_s2;
  logic                 r_uns;
  logic [RD_W-1:0]      r_rd;
  logic                 r_rslt;
  logic [CNT_W-1:0]     r_cnt;

  logic                 w_accept;
  logic                 w_retire;
  logic                 w_unused_rslt;
  logic [CPU_WIDTH-1:0] w_imm_sext;

  // Immediate is sign-extended even for SLTIU.
  assign w_imm_sext    = {{(CPU_WIDTH-12){req_imm[11]}}, req_imm};
  assign w_unused_rslt = ^slt_rslt[CPU_WIDTH-1:1];

  always_comb begin
    w_nxt_state = r_state;
    w_accept    = 1'b0;
    w_retire    = 1'b0;
    req_rdy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_rdy = !flush;
        if (req_vld && !flush) begin
          w_accept    = 1'b1;
          w_nxt_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (r_rd == '0) begin
          w_retire    = !flush;
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_state = S_WB;
        end
      end
      S_WB: begin
        if (wb_rdy) begin
          req_rdy  = !flush;
          w_retire = !flush;
          if (req_vld && !flush) begin
            w_accept    = 1'b1;
            w_nxt_state = S_EXEC;
          end else begin
            w_nxt_state = S_IDLE;
          end
        end
      end
      default: w_nxt_state = S_IDLE;
    endcase
    // Flush overrides every transition, including a same-cycle writeback.
    if (flush) w_nxt_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_s1    <= '0;
      r_s2    <= '0;
      r_uns   <= 1'b0;
      r_rd    <= '0;
      r_rslt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt_state;
      if (w_accept) begin
        r_s1  <= req_s1;
        r_s2  <= req_immFlg ? w_imm_sext : req_s2;
        r_uns <= req_unsigned;
        r_rd  <= req_rd;
      end
      if (r_state == S_EXEC) r_rslt <= slt_rslt[0];
      if (w_retire) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign slt_en       = (r_state == S_EXEC);
  assign slt_s1       = r_s1;
  assign slt_s2       = r_s2;
  assign slt_unsigned = r_uns;
  assign wb_vld       = (r_state == S_WB);
  assign wb_rd        = r_rd;
  assign wb_data      = {{(CPU_WIDTH-1){1'b0}}, r_rslt};
  assign retire_cnt   = r_cnt;

endmodule

// File: tb/tb_rvi_slt_issue_ctrl.sv
// Self-checking bench for rvi_slt_issue_ctrl: directed cases plus randomized traffic
// compared every cycle against an op-age based reference model.
module tb_rvi_slt_issue_ctrl;

  localparam int CW   = 32;
  localparam int RDW  = 5;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic            req_vld;
  logic            req_rdy;
  logic [CW-1:0]   req_s1;
  logic [CW-1:0]   req_s2;
  logic [11:0]     req_imm;
  logic            req_immFlg;
  logic            req_unsigned;
  logic [RDW-1:0]  req_rd;
  logic            slt_en;
  logic [CW-1:0]   slt_s1;
  logic [CW-1:0]   slt_s2;
  logic            slt_unsigned;
  logic [CW-1:0]   slt_rslt;
  logic            wb_vld;
  logic            wb_rdy;
  logic [RDW-1:0]  wb_rd;
  logic [CW-1:0]   wb_data;
  logic [CNTW-1:0] retire_cnt;

  rvi_slt_issue_ctrl #(
    .RV64  (0),
    .RD_W  (RDW),
    .CNT_W (CNTW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_vld      (req_vld),
    .req_rdy      (req_rdy),
    .req_s1       (req_s1),
    .req_s2       (req_s2),
    .req_imm      (req_imm),
    .req_immFlg   (req_immFlg),
    .req_unsigned (req_unsigned),
    .req_rd       (req_rd),
    .slt_en       (slt_en),
    .slt_s1       (slt_s1),
    .slt_s2       (slt_s2),
    .slt_unsigned (slt_unsigned),
    .slt_rslt     (slt_rslt),
    .wb_vld       (wb_vld),
    .wb_rdy       (wb_rdy),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .retire_cnt   (retire_cnt)
  );

  always #5 clk = ~clk;

  // Plain-arithmetic compare: signed order equals unsigned order with the sign bit flipped.
  function automatic logic ref_lt(logic [CW-1:0] a, logic [CW-1:0] b, logic uns);
    if (uns) return a < b;
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  // SLT unit stand-in; upper result bits carry junk the controller must ignore.
  logic [CW-1:0] junk;
  always_comb begin
    slt_rslt = '0;
    if (slt_en) slt_rslt = {junk[CW-1:1], ref_lt(slt_s1, slt_s2, slt_unsigned)};
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: at most one op in flight, tracked by its age in cycles since acceptance.
  bit              m_busy;
  int              m_age;
  logic [CW-1:0]   m_s1;
  logic [CW-1:0]   m_s2;
  logic            m_uns;
  logic [RDW-1:0]  m_rd;
  logic            m_res;
  logic [CNTW-1:0] m_cnt;
  int              wb_seen;

  task automatic m_take();
    m_busy = 1;
    m_age  = 1;
    m_s1   = req_s1;
    m_s2   = req_immFlg ? {{20{req_imm[11]}}, req_imm} : req_s2;
    m_uns  = req_unsigned;
    m_rd   = req_rd;
    m_res  = ref_lt(m_s1, m_s2, m_uns);
  endtask

  task automatic compare();
    bit e_en, e_wb, e_rdy;
    e_en  = m_busy && m_age == 1;
    e_wb  = m_busy && m_age >= 2;
    e_rdy = !flush && (!m_busy || (e_wb && wb_rdy));
    chk("req_rdy", req_rdy, e_rdy);
    chk("slt_en", slt_en, e_en);
    chk("wb_vld", wb_vld, e_wb);
    chk("retire_cnt", retire_cnt, m_cnt);
    if (e_en) begin
      chk("slt_s1", slt_s1, m_s1);
      chk("slt_s2", slt_s2, m_s2);
      chk("slt_unsigned", slt_unsigned, m_uns);
    end
    if (e_wb) begin
      chk("wb_rd", wb_rd, m_rd);
      chk("wb_data", wb_data, {63'd0, m_res});
    end
  endtask

  task automatic advance();
    if (flush) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (req_vld) m_take();
    end else if (m_age == 1) begin
      if (m_rd == 0) begin
        m_cnt++;
        m_busy = 0;
      end else begin
        m_age = 2;
      end
    end else if (wb_rdy) begin
      m_cnt++;
      wb_seen++;
      if (req_vld) m_take();
      else m_busy = 0;
    end else begin
      m_age++;
    end
  endtask

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic cycle();
    #1;
    compare();
    advance();
    @(negedge clk);
  endtask

  task automatic set_op(logic [CW-1:0] s1, logic [CW-1:0] s2, logic [11:0] imm,
                        logic immf, logic uns, logic [RDW-1:0] rd);
    req_s1       = s1;
    req_s2       = s2;
    req_imm      = imm;
    req_immFlg   = immf;
    req_unsigned = uns;
    req_rd       = rd;
  endtask

  task automatic do_reset();
    flush = 0;
    rst_n = 0;
    #1;
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_slt_en", slt_en, 0);
    chk("rst_slt_s1", slt_s1, 0);
    chk("rst_slt_s2", slt_s2, 0);
    chk("rst_slt_unsigned", slt_unsigned, 0);
    chk("rst_wb_vld", wb_vld, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_retire_cnt", retire_cnt, 0);
    m_busy = 0;
    m_cnt  = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // One op start to finish with wb_rdy=1, plus literal checks of the result.
  task automatic op_full(logic [CW-1:0] s1, logic [CW-1:0] s2, logic [11:0] imm,
                         logic immf, logic uns, logic [RDW-1:0] rd,
                         logic exp_data, logic [CNTW-1:0] exp_cnt);
    set_op(s1, s2, imm, immf, uns, rd);
    req_vld = 1;
    wb_rdy  = 1;
    cycle();
    req_vld = 0;
    #1 chk("lit_slt_en_pulse", slt_en, 1);
    cycle();
    if (rd != 0) begin
      #1;
      chk("lit_wb_vld", wb_vld, 1);
      chk("lit_wb_data", wb_data, {63'd0, exp_data});
      chk("lit_wb_rd", wb_rd, rd);
      cycle();
    end
    #1;
    chk("lit_idle_slt_en", slt_en, 0);
    chk("lit_idle_wb_vld", wb_vld, 0);
    chk("lit_retire_cnt", retire_cnt, exp_cnt);
  endtask

  initial begin
    logic [CW-1:0]  hold_data;
    logic [RDW-1:0] hold_rd;
    int             base;
    logic [CW-1:0]  pool [6];

    pool[0] = 32'h0;         pool[1] = 32'h1;         pool[2] = 32'hFFFF_FFFF;
    pool[3] = 32'h8000_0000; pool[4] = 32'h7FFF_FFFF; pool[5] = 32'h5;
    junk    = '0;
    wb_seen = 0;
    req_vld = 0;
    wb_rdy  = 0;
    set_op('0, '0, '0, 0, 0, '0);
    do_reset();

    // SLT -1 < 1, SLTU same, SLTIU 5 < 0xFFFFFFFF, SLTI 5 < -1.
    op_full(32'hFFFF_FFFF, 32'h1, 12'h0, 0, 0, 5'd3, 1, 4'd1);
    op_full(32'hFFFF_FFFF, 32'h1, 12'h0, 0, 1, 5'd3, 0, 4'd2);
    op_full(32'h5, 32'h0, 12'hFFF, 1, 1, 5'd7, 1, 4'd3);
    op_full(32'h5, 32'h0, 12'hFFF, 1, 0, 5'd7, 0, 4'd4);
    // rd=0 op: no writeback, still retires.
    op_full(32'h1, 32'h2, 12'h0, 0, 0, 5'd0, 1, 4'd5);

    // Back-to-back: four ops with req_vld held.
    @(negedge clk);
    base = wb_seen;
    wb_rdy = 1;
    for (int i = 0; i < 9; i++) begin
      req_vld = (i < 7);
      set_op($urandom, $urandom, 12'h0, 0, 1'($urandom), 5'(i + 1));
      #1 if (i < 8) chk("b2b_req_rdy", req_rdy, (i % 2) == 0);
      cycle();
    end
    chk("b2b_wb_count", wb_seen - base, 4);

    // Backpressure for five cycles in WB.
    op_full(32'h8000_0000, 32'h7FFF_FFFF, 12'h0, 0, 0, 5'd9, 1, 4'd10);
    set_op(32'h3, 32'h2, 12'h0, 0, 0, 5'd12);
    req_vld = 1;
    cycle();
    wb_rdy = 0;
    cycle();
    #1;
    hold_data = wb_data;
    hold_rd   = wb_rd;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_wb_vld", wb_vld, 1);
      chk("bp_wb_data", wb_data, hold_data);
      chk("bp_wb_rd", wb_rd, hold_rd);
      chk("bp_req_rdy", req_rdy, 0);
      chk("bp_slt_en", slt_en, 0);
      cycle();
    end
    req_vld = 0;
    wb_rdy  = 1;
    cycle();
    #1 chk("bp_retire_cnt", retire_cnt, 4'd11);

    // Flush in EXEC.
    set_op(32'h1, 32'h2, 12'h0, 0, 0, 5'd4);
    req_vld = 1;
    cycle();
    req_vld = 0;
    flush = 1;
    cycle();
    flush = 0;
    #1;
    chk("flx_wb_vld", wb_vld, 0);
    chk("flx_retire_cnt", retire_cnt, 4'd11);
    cycle();

    // Flush in WB with wb_rdy=1 and a competing request.
    req_vld = 1;
    cycle();
    req_vld = 0;
    cycle();
    flush = 1;
    req_vld = 1;
    #1 chk("flw_req_rdy", req_rdy, 0);
    cycle();
    flush = 0;
    req_vld = 0;
    #1;
    chk("flw_wb_vld", wb_vld, 0);
    chk("flw_slt_en", slt_en, 0);
    chk("flw_retire_cnt", retire_cnt, 4'd11);
    cycle();

    // Reset asserted while an op sits in WB.
    req_vld = 1;
    wb_rdy  = 0;
    cycle();
    req_vld = 0;
    cycle();
    #2 do_reset();

    // Randomized traffic; 4-bit counter wraps many times.
    for (int i = 0; i < 3000; i++) begin
      junk    = $urandom;
      flush   = ($urandom_range(15) == 0);
      req_vld = ($urandom_range(2) != 0);
      wb_rdy  = ($urandom_range(3) != 0);
      set_op(($urandom_range(1) != 0) ? pool[$urandom_range(5)] : $urandom,
             ($urandom_range(1) != 0) ? pool[$urandom_range(5)] : $urandom,
             ($urandom_range(1) != 0) ? 12'(pool[$urandom_range(5)]) : 12'($urandom),
             1'($urandom), 1'($urandom),
             ($urandom_range(3) == 0) ? 5'd0 : 5'($urandom));
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
